ghidich: RTL and testbench

GHIDICH -- requirements
Module: ghidich

---
 rtl/ghidich.sv | 46 ++++
 tb/tb_ghidich.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/ghidich.sv
// Serial-in/serial-out shift register of WIDTH stages.
// A free-running divider advances it once every DIV clk cycles.
module ghidich #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV   = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic s_in,
    output logic s_out
);

    localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0]    cnt;
    logic             tick;
    logic [WIDTH-1:0] q;

    // With DIV=1 LAST is 0, so tick stays high and cnt never leaves 0.
    assign tick = (cnt == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (tick) begin
            q[0] <= s_in;
            for (int unsigned i = 1; i < WIDTH; i++) begin
                q[i] <= q[i-1];
            end
        end
    end

    assign s_out = q[WIDTH-1];

endmodule

// File: tb/tb_ghidich.sv
// Directed bench for ghidich: DIV=4/WIDTH=8 instance plus a DIV=1/WIDTH=1 instance.
module tb_ghidich;

    logic clk;
    logic reset;
    logic s_in;
    logic s_out;
    logic reset_b;
    logic s_in_b;
    logic s_out_b;

    int n_vec = 0;
    int n_bad = 0;

    ghidich #(.WIDTH(8), .DIV(4)) u_dut (
        .clk   (clk),
        .reset (reset),
        .s_in  (s_in),
        .s_out (s_out)
    );

    ghidich #(.WIDTH(1), .DIV(1)) u_dut_b (
        .clk   (clk),
        .reset (reset_b),
        .s_in  (s_in_b),
        .s_out (s_out_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves the bench just after the negedge where reset is released,
    // so the next posedge is edge 1 after release.
    task automatic do_reset(input logic sin);
        @(negedge clk);
        reset = 1'b0;
        s_in  = sin;
        #1 check("rst_async", s_out, 1'b0);
        repeat (5) @(posedge clk);
        #1 check("rst_hold", s_out, 1'b0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [7:0]  pat;
        logic [15:0] pat_b;
        logic        want;

        reset   = 1'b0;
        s_in    = 1'b0;
        reset_b = 1'b0;
        s_in_b  = 1'b0;
        pat     = 8'b0100_1101;   // pat[0..7] = 1,0,1,1,0,0,1,0
        pat_b   = 16'b1011_0010_1110_0100;

        // Idle zeros: nothing but zero ever appears
        do_reset(1'b0);
        for (int e = 1; e <= 40; e++) begin
            adv(1);
            check("zero_idle", s_out, 1'b0);
        end

        // Constant one: first tick at edge 4, s_out rises at edge 32
        do_reset(1'b1);
        adv(28);
        check("ones_e28", s_out, 1'b0);
        adv(3);
        check("ones_e31", s_out, 1'b0);
        adv(1);
        check("ones_e32", s_out, 1'b1);
        for (int e = 0; e < 8; e++) begin
            adv(1);
            check("ones_hold", s_out, 1'b1);
        end

        // Pattern shifted one bit per tick, each output bit held 4 clk
        do_reset(pat[0]);
        for (int k = 0; k < 8; k++) begin
            s_in = pat[k];
            adv(4);
            s_in = 1'b0;
            if (k == 6) check("pat_tick7", s_out, 1'b0);
        end
        for (int j = 0; j < 8; j++) begin
            check("pat_tick", s_out, pat[j]);
            adv(3);
            check("pat_held", s_out, pat[j]);
            adv(1);
        end
        check("pat_drain", s_out, 1'b0);

        // Glitching input: only the level at each tick edge is captured
        do_reset(1'b0);
        for (int e = 1; e <= 32; e++) begin
            want = (e % 4 == 0);
            s_in = ~want;
            #2 s_in = want;
            @(posedge clk);
            #1;
            s_in = ~want;
            if (e == 28) check("glitch_e28", s_out, 1'b0);
            if (e == 31) check("glitch_e31", s_out, 1'b0);
            if (e == 32) check("glitch_e32", s_out, 1'b1);
        end

        // Full of ones; async reset mid-cycle and mid-divider-phase
        s_in = 1'b1;
        adv(2);
        check("full_pre_rst", s_out, 1'b1);
        #2 reset = 1'b0;
        #1 check("rst_mid_async", s_out, 1'b0);
        adv(2);
        check("rst_mid_hold", s_out, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        adv(31);
        check("rst_mid_e31", s_out, 1'b0);
        adv(1);
        check("rst_mid_e32", s_out, 1'b1);

        // DIV=1, WIDTH=1: s_out is s_in delayed by one clk, no comb path
        @(negedge clk);
        check("b_rst", s_out_b, 1'b0);
        reset_b = 1'b1;
        for (int e = 0; e < 16; e++) begin
            s_in_b = pat_b[e];
            @(posedge clk);
            #1 check("b_delay1", s_out_b, pat_b[e]);
            s_in_b = ~pat_b[e];
            #1 check("b_no_comb", s_out_b, pat_b[e]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
